// File: rtl/dse_sink_pkg.sv
// dse_sink_pkg: shared DSE widths, record magic numbers, serializer state and beat-count helper
package dse_sink_pkg;
    localparam int DSE_DATA_W  = 376;
    localparam int DSE_MAGIC_W = 8;
    localparam int DSE_OUT_W   = 64;
    localparam int MAGIC_EMULATE = 1;
    localparam int MAGIC_DEG     = 2;
    localparam int MAGIC_DEGDONE = 3;
    localparam int MAGIC_FINISH  = 4;
    typedef enum logic {S_IDLE, S_SEND} sink_state_e;
    function automatic int beats_of(input int rec_w, input int out_w);
        return (rec_w + out_w - 1) / out_w;
    endfunction
endpackage

// File: rtl/dse_record_fifo.sv
// dse_record_fifo: synchronous FIFO with registered level counter and combinational head read
// Ports: clock/reset (sync, active-high); push/push_data write a record; pop retires the head;
// head is the oldest stored record; level is the stored entry count.
// The caller never pushes when full nor pops when empty.
module dse_record_fifo #(
    parameter int W = 384,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
endmodule

// File: rtl/dse_record_sink.sv
// dse_record_sink: buffers tagged DSE records and serializes them into OUT_W beats on a valid/ready stream
// Ports: clock/reset (sync, active-high); in_enable/in_data carry one {magic, payload} record per cycle;
// out_valid/out_ready/out_data/out_last form the beat stream (LSB beat first);
// drop_count counts dropped DEG records (saturating), overflow is sticky on the first drop,
// fifo_level is the stored record count.
module dse_record_sink
    import dse_sink_pkg::*;
#(
    parameter int DATA_W = DSE_DATA_W,
    parameter int MAGIC_W = DSE_MAGIC_W,
    parameter int OUT_W = DSE_OUT_W,
    parameter int DEPTH = 8,
    localparam int REC_W = DATA_W + MAGIC_W,
    localparam int BEATS = beats_of(REC_W, OUT_W),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_enable,
    input  logic [REC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [31:0]      drop_count,
    output logic             overflow,
    output logic [LW-1:0]    fifo_level
);
    localparam int SW = BEATS * OUT_W;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;

    logic [MAGIC_W-1:0] magic;
    logic               rec_in, is_deg, push, pop, drop, lost, fire, last_beat;
    logic [REC_W-1:0]   head;
    logic [LW-1:0]      level;
    sink_state_e        state_q, state_d;
    logic [SW-1:0]      shreg_q, shreg_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [31:0]        drop_q, drop_d;
    logic               ovf_q, ovf_d;

    dse_record_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .level     (level)
    );

    // The last FIFO slot is reserved for control records so DEG floods never starve them.
    always_comb begin
        magic     = in_data[REC_W-1 -: MAGIC_W];
        rec_in    = in_enable && magic != '0;
        is_deg    = magic == MAGIC_W'(MAGIC_DEG);
        push      = rec_in && (is_deg ? level < LW'(DEPTH - 1) : level < LW'(DEPTH));
        drop      = rec_in && is_deg && !push;
        lost      = rec_in && !is_deg && !push;
        last_beat = beat_q == BW'(BEATS - 1);
        fire      = state_q == S_SEND && out_ready;
        pop       = level != '0 && (state_q == S_IDLE || (fire && last_beat));
        state_d   = pop ? S_SEND : (fire && last_beat) ? S_IDLE : state_q;
        shreg_d   = pop ? SW'(head) : fire ? shreg_q >> OUT_W : shreg_q;
        beat_d    = pop ? '0 : fire ? beat_q + 1'b1 : beat_q;
        drop_d    = (drop && drop_q != '1) ? drop_q + 32'd1 : drop_q;
        ovf_d     = ovf_q || drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && lost) $display("dse_record_sink: control record magic %0d lost at full FIFO", magic);
    end
`endif

    assign out_valid  = state_q == S_SEND;
    assign out_data   = shreg_q[OUT_W-1:0];
    assign out_last   = out_valid && last_beat;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;
    assign fifo_level = level;
endmodule

// File: tb/tb_dse_record_sink.sv
// tb_dse_record_sink: randomized and directed checks of dse_record_sink against a queue-based model
module tb_dse_record_sink;
    import dse_sink_pkg::*;
    localparam int DATA_W = 376, MAGIC_W = 8, OUT_W = 64, DEPTH = 8;
    localparam int REC_W = DATA_W + MAGIC_W, BEATS = 6, LW = 4;
    localparam int MPOS = REC_W - 1 - (BEATS - 1) * OUT_W;

    logic             clock = 1'b0;
    logic             reset, in_enable, out_ready;
    logic [REC_W-1:0] in_data;
    logic             out_valid, out_last, overflow;
    logic [OUT_W-1:0] out_data;
    logic [31:0]      drop_count;
    logic [LW-1:0]    fifo_level;

    dse_record_sink #(.DATA_W(DATA_W), .MAGIC_W(MAGIC_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_enable  (in_enable),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .drop_count (drop_count),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;

    // Reference: FIFO contents as a queue, the record being sent and its beat number.
    logic [REC_W-1:0] mq[$];
    logic [REC_W-1:0] m_cur = '0;
    bit               m_send = 0, m_ovf = 0;
    int               m_beat = 0;
    logic [31:0]      m_drop = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input logic [MAGIC_W-1:0] m);
        logic [REC_W-1:0] r;
        for (int i = 0; i < REC_W / 32; i++) r[i*32 +: 32] = $urandom;
        r[REC_W-1 -: MAGIC_W] = m;
        return r;
    endfunction

    task automatic model_step();
        int lvl;
        logic [MAGIC_W-1:0] mg;
        if (reset) begin
            mq.delete();
            m_send = 0;
            m_beat = 0;
            m_drop = 0;
            m_ovf = 0;
            return;
        end
        lvl = mq.size();
        mg = in_data[REC_W-1 -: MAGIC_W];
        if (!m_send) begin
            if (lvl > 0) begin
                m_cur = mq.pop_front();
                m_send = 1;
                m_beat = 0;
            end
        end else if (out_ready) begin
            if (m_beat == BEATS - 1) begin
                if (lvl > 0) begin
                    m_cur = mq.pop_front();
                    m_beat = 0;
                end else m_send = 0;
            end else m_beat++;
        end
        if (in_enable && mg != 0) begin
            if (mg == MAGIC_DEG ? lvl <= DEPTH - 2 : lvl <= DEPTH - 1) mq.push_back(in_data);
            else if (mg == MAGIC_DEG) begin
                if (m_drop != 32'hFFFF_FFFF) m_drop++;
                m_ovf = 1;
            end
        end
    endtask

    task automatic compare();
        check("valid", out_valid, m_send);
        check("last", out_last, m_send && m_beat == BEATS - 1);
        if (m_send) check("data", out_data, m_cur[m_beat*OUT_W +: OUT_W]);
        check("level", fifo_level, mq.size());
        check("drops", drop_count, m_drop);
        check("ovf", overflow, m_ovf);
    endtask

    task automatic step(input bit rst, input bit en, input logic [REC_W-1:0] d, input bit rdy);
        reset = rst;
        in_enable = en;
        in_data = d;
        out_ready = rdy;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    initial begin
        int nvalid, run, maxrun, lasts, readyp;
        logic [MAGIC_W-1:0] mag;
        logic [OUT_W-1:0] held;
        bit stalled;
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        check("rst_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drops", drop_count, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

        // Single emulate record: two-cycle latency, six beats, magic in the last beat's top bits.
        step(0, 1, mk_rec(MAGIC_W'(MAGIC_EMULATE)), 1);
        check("lat_first", out_valid, 0);
        step(0, 0, '0, 1);
        check("lat_second", out_valid, 1);
        nvalid = 1;
        mag = '0;
        for (int i = 0; i < 8; i++) begin
            if (out_last) mag = out_data[MPOS -: MAGIC_W];
            step(0, 0, '0, 1);
            if (out_valid) nvalid++;
        end
        check("single_beats", nvalid, BEATS);
        check("single_magic", mag, MAGIC_EMULATE);

        // Back-pressure mid-record holds the beat.
        step(0, 1, mk_rec(MAGIC_W'(MAGIC_DEGDONE)), 1);
        stalled = 0;
        held = '0;
        for (int i = 0; i < 12; i++) begin
            bit rdy = !(i inside {3, 4, 5});
            if (stalled) check("hold", out_data, held);
            held = out_data;
            stalled = out_valid && !rdy;
            step(0, 0, '0, rdy);
        end

        // DEG flood behind a stalled record: seven admitted, thirteen dropped, finish still fits.
        step(0, 1, mk_rec(MAGIC_W'(MAGIC_EMULATE)), 0);
        step(0, 0, '0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, mk_rec(MAGIC_W'(MAGIC_DEG)), 0);
        check("flood_level", fifo_level, DEPTH - 1);
        check("flood_drops", drop_count, 13);
        check("flood_ovf", overflow, 1);
        step(0, 1, mk_rec(MAGIC_W'(MAGIC_FINISH)), 0);
        check("finish_level", fifo_level, DEPTH);
        mag = '0;
        for (int i = 0; i < 60; i++) begin
            if (out_last) mag = out_data[MPOS -: MAGIC_W];
            step(0, 0, '0, 1);
        end
        check("finish_kept", mag, MAGIC_FINISH);
        check("drained", fifo_level, 0);

        // Back-to-back records stream without a bubble.
        run = 0;
        maxrun = 0;
        lasts = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, i < 2, mk_rec(MAGIC_W'(i == 0 ? MAGIC_DEGDONE : MAGIC_EMULATE)), 1);
            run = out_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (out_last) lasts++;
        end
        check("b2b_run", maxrun, 2 * BEATS);
        check("b2b_lasts", lasts, 2);

        // Reset during beat 3 discards the record and clears the counters.
        step(0, 1, mk_rec(MAGIC_W'(MAGIC_EMULATE)), 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
        check("pre_rst_beat3", out_valid && m_beat == 3, 1);
        step(1, 0, '0, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_drops", drop_count, 0);
        check("mid_rst_ovf", overflow, 0);
        step(0, 0, '0, 1);
        check("no_resume", out_valid, 0);

        // Random traffic with varying back-pressure.
        readyp = 50;
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [MAGIC_W-1:0] m;
            if (i % 200 == 0) readyp = $urandom_range(0, 2) == 0 ? 10 : ($urandom_range(0, 1) ? 50 : 90);
            r = $urandom_range(0, 19);
            m = r == 0 ? 8'd0 : r <= 16 ? 8'(MAGIC_DEG) : r == 17 ? 8'(MAGIC_EMULATE) : r == 18 ? 8'(MAGIC_DEGDONE) : 8'(MAGIC_FINISH);
            step($urandom_range(0, 499) == 0, $urandom_range(0, 1), mk_rec(m), $urandom_range(0, 99) < readyp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
